mdu_seq: RTL
============

# mdu_seq

Multi-cycle unsigned multiply/divide sequencer for the HI/LO unit of the execute stage. It runs MULTU and DIVU on 32-bit operands by driving one `alu` instance iteratively: shift-and-add for multiply, restoring division for divide. The block accepts one operation at a time through a start/busy/done handshake. It holds the 64-bit result on `hi`/`lo` until the next operation completes.

## Interface
Parameters:
- none; operand width is fixed at 32 and the iteration count at 32.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  1  0 = MULTU, 1 = DIVU; sampled with `start`
- `src_a`  in  32  multiplicand / dividend; sampled with `start`
- `src_b`  in  32  multiplier / divisor; sampled with `start`
- `busy`  out  1  high while state ≠ IDLE
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle
- `hi`  out  32  MULTU: product[63:32]; DIVU: remainder
- `lo`  out  32  MULTU: product[31:0]; DIVU: quotient

## Operation
- States: IDLE → RUN (exactly 32 cycles, 5-bit counter 0..31) → DONE (1 cycle) → IDLE.
- Accept: in IDLE with `start`=1, latch `op`, `src_b` into the operand register and initialise the working registers:
  - MULTU: whi=0, wlo=`src_a`.
  - DIVU: whi=0, wlo=`src_a` (dividend).
- MULTU iteration:
  - ALU ctl=ADD, data_1=whi, data_2 = wlo[0] ? operand : 0.
  - Carry = (res < whi), unsigned, computed locally.
  - {whi,wlo} ← {carry, res, wlo[31:1]}.
- DIVU iteration:
  - sh = {whi[30:0], wlo[31]}, msb = whi[31].
  - ge = msb | (sh ≥ operand), unsigned, computed locally.
  - ALU ctl=SUB, data_1=sh, data_2=operand.
  - whi ← ge ? res : sh; wlo ← {wlo[30:0], ge}. The 32-bit wrap of SUB is exact because the result is below the divisor.
- Divide by zero needs no special case. The natural result is `lo`=32'hFFFFFFFF and `hi`=dividend, with normal latency.
- `hi`/`lo` are output registers separate from whi/wlo:
  - Loaded only on the RUN→DONE transition, from the final iteration's next values.
  - Otherwise hold their value, including throughout the next operation's RUN.
- `start` while busy, including in the DONE cycle, is ignored and not queued.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE, counter=0, `busy`=0, `done`=0, `hi`=0, `lo`=0, whi/wlo=0. Reset has priority over everything and aborts any operation mid-RUN; no `done` is produced.
- Accept edge E0. After E0: `busy`=1.
- Iterations occur at edges E1..E32. After E32: state=DONE, `done`=1, `hi`/`lo` hold the new result.
- After E33: state=IDLE, `busy`=0, `done`=0. The earliest next accept is edge E34.
- Latency: `done` is visible 32 cycles after `start` is sampled. Throughput is one operation per 34 cycles.
- `busy` is high for 33 cycles per operation.

## Structure
- Shared package `mips_pkg`:
  - ALU control constants AND=3'b000, OR=3'b001, ADD=3'b010, SUB=3'b110, SET_LT=3'b111.
  - MDU op encoding (MULTU=1'b0, DIVU=1'b1).
  - State enum {IDLE, RUN, DONE}.
- One sub-module: the team's existing `alu`, instantiated once as `u_alu`.
- Carry and compare logic, the counter and the FSM live in `mdu_seq`.

## Test plan
- MULTU 3 × 5 → `hi`=0, `lo`=15; `done` high exactly 32 cycles after the start edge for one cycle; `busy` high 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001 (exercises carry out of the ALU).
- DIVU 100 / 7 → `lo`=14, `hi`=2. Then DIVU 0xFFFFFFFE / 0x80000001 → `lo`=1, `hi`=0x7FFFFFFD (exercises the msb path).
- DIVU 0x12345678 / 0 → `lo`=0xFFFFFFFF, `hi`=0x12345678, with normal latency.
- MULTU 2 × 2, then `start` pulsed with different operands at cycles 5 and 33 (DONE) → ignored; result stays `lo`=4, and the previous `hi`/`lo` are stable during RUN.
- `rst_n` low for 1 cycle at RUN iteration 10 → next cycle `busy`=0, `hi`=`lo`=0, no `done` pulse; a following DIVU 9 / 3 → `lo`=3, `hi`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared execute-stage definitions: ALU control codes, MDU op encoding, sequencer states.
package mips_pkg;

   localparam logic [2:0] ALU_AND    = 3'b000;
   localparam logic [2:0] ALU_OR     = 3'b001;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SUB    = 3'b110;
   localparam logic [2:0] ALU_SET_LT = 3'b111;

   localparam logic MDU_MULTU = 1'b0;
   localparam logic MDU_DIVU  = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

endpackage

// File: rtl/alu.sv
// 32-bit execute-stage ALU: AND, OR, ADD, SUB and signed set-less-than.
module alu
   import mips_pkg::*;
(
   input  logic [2:0]  ctl_i,
   input  logic [31:0] data_1_i,
   input  logic [31:0] data_2_i,
   output logic [31:0] res_o
);

   // Select the operation result from the control code.
   always_comb begin
      res_o = '0;
      case (ctl_i)
         ALU_AND:    res_o = data_1_i & data_2_i;
         ALU_OR:     res_o = data_1_i | data_2_i;
         ALU_ADD:    res_o = data_1_i + data_2_i;
         ALU_SUB:    res_o = data_1_i - data_2_i;
         ALU_SET_LT: res_o = {31'b0, ($signed(data_1_i) < $signed(data_2_i))};
         default:    res_o = '0;
      endcase
   end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer driving one shared ALU for 32 iterations.
module mdu_seq
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        op_q, op_d;
   logic [31:0] operand_q, operand_d;
   logic [31:0] whi_q, whi_d;
   logic [31:0] wlo_q, wlo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [2:0]  alu_ctl;
   logic [31:0] alu_d1, alu_d2, alu_res;
   logic [31:0] sh;
   logic        ge;
   logic        carry;
   logic [31:0] iter_hi, iter_lo;

   alu u_alu (
      .ctl_i    (alu_ctl),
      .data_1_i (alu_d1),
      .data_2_i (alu_d2),
      .res_o    (alu_res)
   );

   // Drive ALU operands: add-if-bit-set for multiply, trial subtract for divide.
   always_comb begin
      sh = {whi_q[30:0], wlo_q[31]};
      if (op_q == MDU_DIVU) begin
         alu_ctl = ALU_SUB;
         alu_d1  = sh;
         alu_d2  = operand_q;
      end else begin
         alu_ctl = ALU_ADD;
         alu_d1  = whi_q;
         alu_d2  = wlo_q[0] ? operand_q : 32'd0;
      end
   end

   // Form one iteration's next working values from the ALU result.
   always_comb begin
      // Addend is below 2^32, so a wrapped sum is always smaller than the old high word.
      carry = (alu_res < whi_q);
      // A set msb means the shifted remainder exceeds 32 bits and must exceed the divisor.
      ge    = whi_q[31] | (sh >= operand_q);
      if (op_q == MDU_DIVU) begin
         iter_hi = ge ? alu_res : sh;
         iter_lo = {wlo_q[30:0], ge};
      end else begin
         iter_hi = {carry, alu_res[31:1]};
         iter_lo = {alu_res[0], wlo_q[31:1]};
      end
   end

   // Next-state logic: accept in idle, iterate 32 times, publish result on the last one.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      operand_d = operand_q;
      whi_d     = whi_q;
      wlo_d     = wlo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               cnt_d     = 5'd0;
               op_d      = op;
               operand_d = src_b;
               whi_d     = 32'd0;
               wlo_d     = src_a;
            end
         end
         StRun: begin
            whi_d = iter_hi;
            wlo_d = iter_lo;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = StDone;
               hi_d    = iter_hi;
               lo_d    = iter_lo;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 5'd0;
         op_q      <= MDU_MULTU;
         operand_q <= 32'd0;
         whi_q     <= 32'd0;
         wlo_q     <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         whi_q     <= whi_d;
         wlo_q     <= wlo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
